// File: rtl/cardinal_nic_tx_sched.sv
`default_nettype none
// ============================================================================
//  Module      : cardinal_nic_tx_sched
//  Description : Transmit-side scheduler for the NIC output channel buffer.
//                Round-robin arbitration among NUM_REQ local requesters for a
//                single-entry status-flag buffer, then drains each packet to
//                the router over the so/ro handshake, gated by the network
//                polarity (packet VC bit must equal net_polarity_i).
//  Ports       : clk_i, reset_i (sync, active-low)
//                req_i / req_data_i / grant_o        requester side
//                buf_write_en_o / buf_read_en_o /
//                buf_data_in_o / buf_data_out_i /
//                buf_status_i                        buffer side
//                net_so_o / net_ro_i / net_do_o /
//                net_polarity_i                      router side
//                err_timeout_o                       sticky send-stall error
//  Options     : CARDINAL_NIC_SEND_TIMEOUT_EN enables the ST_SEND stall
//                counter and err_timeout_o; otherwise err_timeout_o is 0.
//  Packet bits : the packet is numbered [0:W-1] with bit 0 the VC bit. On
//                these descending vectors that bit is the MSB, [W-1].
//  Revision    : 1.0 - initial release
// ============================================================================
module cardinal_nic_tx_sched #(
    parameter int NUM_REQ        = 4,
    parameter int BUFFER_WIDTH   = 64,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                              clk_i,
    input  logic                              reset_i,
    input  logic [NUM_REQ-1:0]                req_i,
    input  logic [NUM_REQ*BUFFER_WIDTH-1:0]   req_data_i,
    output logic [NUM_REQ-1:0]                grant_o,
    output logic                              buf_write_en_o,
    output logic                              buf_read_en_o,
    output logic [BUFFER_WIDTH-1:0]           buf_data_in_o,
    input  logic [BUFFER_WIDTH-1:0]           buf_data_out_i,
    input  logic                              buf_status_i,
    output logic                              net_so_o,
    input  logic                              net_ro_i,
    output logic [BUFFER_WIDTH-1:0]           net_do_o,
    input  logic                              net_polarity_i,
    output logic                              err_timeout_o
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_FILL  = 2'd1;
    localparam logic [1:0] ST_SEND  = 2'd2;
    localparam logic [1:0] ST_DRAIN = 2'd3;

    logic [1:0]              state_q, state_d;
    logic [PTR_W-1:0]        rr_ptr_q, rr_ptr_d;

    logic                    w_found;
    logic [PTR_W-1:0]        w_winner;
    logic                    w_grant_fire;
    logic                    w_send_fire;
    logic [BUFFER_WIDTH-1:0] w_sel_data;

    // Round-robin pick: scan downward so the last hit kept is the nearest
    // set request at or after rr_ptr_q (wrapping).
    always_comb begin : arbitrate
        int idx;
        w_found  = 1'b0;
        w_winner = '0;
        idx      = 0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = (int'(rr_ptr_q) + k) % NUM_REQ;
            if (req_i[idx]) begin
                w_found  = 1'b1;
                w_winner = PTR_W'(idx);
            end
        end
    end

    // Outputs are gated by reset_i so nothing leaves the block while reset
    // is held, even with requests pending on the first reset cycle.
    assign w_grant_fire = reset_i && (state_q == ST_IDLE) && w_found && !buf_status_i;
    assign w_send_fire  = reset_i && (state_q == ST_SEND) && net_ro_i &&
                          (buf_data_out_i[BUFFER_WIDTH-1] == net_polarity_i);

    assign w_sel_data     = req_data_i[int'(w_winner)*BUFFER_WIDTH +: BUFFER_WIDTH];

    assign grant_o        = w_grant_fire ? (NUM_REQ'(1) << w_winner) : '0;
    assign buf_write_en_o = w_grant_fire;
    assign buf_data_in_o  = w_grant_fire ? w_sel_data : '0;
    assign buf_read_en_o  = w_send_fire;
    assign net_so_o       = w_send_fire;
    assign net_do_o       = w_send_fire ? buf_data_out_i : '0;

    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        case (state_q)
            ST_IDLE: begin
                if (w_grant_fire) begin
                    state_d  = ST_FILL;
                    rr_ptr_d = (w_winner == PTR_W'(NUM_REQ - 1)) ? '0 : w_winner + PTR_W'(1);
                end
            end
            ST_FILL:  if (buf_status_i)  state_d = ST_SEND;
            ST_SEND:  if (w_send_fire)   state_d = ST_DRAIN;
            ST_DRAIN: if (!buf_status_i) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            state_q  <= ST_IDLE;
            rr_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

`ifdef CARDINAL_NIC_SEND_TIMEOUT_EN
    localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;

    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic             err_timeout_q, err_timeout_d;
    logic             w_stall;

    assign w_stall = (state_q == ST_SEND) && !w_send_fire;

    // Counter saturates at the limit; the error flag is sticky until reset
    // and never interrupts the wait for the router.
    always_comb begin
        stall_cnt_d   = stall_cnt_q;
        err_timeout_d = err_timeout_q;
        if ((state_q == ST_FILL) && (state_d == ST_SEND)) begin
            stall_cnt_d = '0;
        end else if (w_stall && (stall_cnt_q != CNT_W'(TIMEOUT_CYCLES))) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
        if (w_stall && (stall_cnt_d == CNT_W'(TIMEOUT_CYCLES))) begin
            err_timeout_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            stall_cnt_q   <= '0;
            err_timeout_q <= 1'b0;
        end else begin
            stall_cnt_q   <= stall_cnt_d;
            err_timeout_q <= err_timeout_d;
        end
    end

    assign err_timeout_o = err_timeout_q;
`else
    assign err_timeout_o = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_cardinal_nic_tx_sched.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cardinal_nic_tx_sched
//  Description : Self-checking bench for cardinal_nic_tx_sched. Models the
//                single-entry buffer and predicts every output each cycle
//                from a transaction-level view (grant age, send age).
//  Revision    : 1.0 - initial release
// ============================================================================
`define CHK(TAG, OBS, EXP) begin \
    n_checks++; \
    assert ((OBS) === (EXP)) else begin \
        n_err++; \
        $error("FAIL %s observed=%0h expected=%0h", TAG, OBS, EXP); \
    end \
end

module tb_cardinal_nic_tx_sched;

    localparam int NR = 4;
    localparam int W  = 64;
    localparam int TO = 10;

    logic              clk = 1'b0;
    logic              reset;
    logic [NR-1:0]     req;
    logic [NR*W-1:0]   req_data;
    logic [NR-1:0]     grant;
    logic              bwe, bre;
    logic [W-1:0]      bdin, bdout;
    logic              bstat;
    logic              so, ro;
    logic [W-1:0]      ndo;
    logic              pol;
    logic              err;

    int n_checks = 0;
    int n_err    = 0;

    cardinal_nic_tx_sched #(
        .NUM_REQ        (NR),
        .BUFFER_WIDTH   (W),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk_i          (clk),
        .reset_i        (reset),
        .req_i          (req),
        .req_data_i     (req_data),
        .grant_o        (grant),
        .buf_write_en_o (bwe),
        .buf_read_en_o  (bre),
        .buf_data_in_o  (bdin),
        .buf_data_out_i (bdout),
        .buf_status_i   (bstat),
        .net_so_o       (so),
        .net_ro_i       (ro),
        .net_do_o       (ndo),
        .net_polarity_i (pol),
        .err_timeout_o  (err)
    );

    always #5 clk = ~clk;

    // Single-entry buffer: write fills, read empties, reset from the same net.
    always @(posedge clk) begin
        if (!reset) begin
            bstat <= 1'b0;
            bdout <= '0;
        end else if (bwe && !bstat) begin
            bstat <= 1'b1;
            bdout <= bdin;
        end else if (bre && bstat) begin
            bstat <= 1'b0;
        end
    end

    // Reference model state: one packet in flight, tracked by its age since grant.
    bit          m_busy  = 1'b0;
    int          m_age   = 0;
    int          m_sent  = -1;
    int          m_rr    = 0;
    int          m_stall = 0;
    bit          m_err   = 1'b0;
    logic [W-1:0] m_pkt  = '0;

    // Last sampled outputs, for directed checks after a step.
    logic [NR-1:0] s_grant;
    logic          s_so, s_err, s_we;
    logic [W-1:0]  s_do;

    task automatic chk_val(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_cycle();
        logic [NR-1:0] eg;
        logic          ewe, eso, eerr;
        logic [W-1:0]  edin, edo;
        int            w;
        eg = '0; ewe = 1'b0; eso = 1'b0; edin = '0; edo = '0; w = -1;
        eerr = m_err;
        if (reset) begin
            if (m_busy) begin
                m_age++;
                // Send at age s, drain at s+1, free again at s+2.
                if (m_sent >= 0 && m_age == m_sent + 2) m_busy = 1'b0;
            end
            if (!m_busy) begin
                for (int k = 0; k < NR; k++)
                    if (w < 0 && req[(m_rr + k) % NR]) w = (m_rr + k) % NR;
                if (w >= 0) begin
                    eg[w]   = 1'b1;
                    ewe     = 1'b1;
                    edin    = req_data[w*W +: W];
                    m_pkt   = edin;
                    m_busy  = 1'b1;
                    m_age   = 0;
                    m_sent  = -1;
                    m_stall = 0;
                    m_rr    = (w + 1) % NR;
                end
            end else if (m_sent < 0 && m_age >= 2) begin
                // Packet VC bit is the MSB of the descending vector.
                if (ro && (m_pkt[W-1] == pol)) begin
                    eso    = 1'b1;
                    edo    = m_pkt;
                    m_sent = m_age;
                end else begin
                    m_stall++;
`ifdef CARDINAL_NIC_SEND_TIMEOUT_EN
                    if (m_stall == TO) m_err = 1'b1;
`endif
                end
            end
        end
        `CHK("grant",    grant, eg)
        `CHK("write_en", bwe,   ewe)
        `CHK("data_in",  bdin,  edin)
        `CHK("read_en",  bre,   eso)
        `CHK("net_so",   so,    eso)
        `CHK("net_do",   ndo,   edo)
        `CHK("err",      err,   eerr)
        s_grant = grant; s_so = so; s_do = ndo; s_err = err; s_we = bwe;
        if (!reset) begin
            m_busy = 1'b0; m_rr = 0; m_err = 1'b0; m_stall = 0; m_sent = -1;
        end
    endtask

    task automatic step();
        @(negedge clk);
        check_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic set_slot(input int i, input logic [W-1:0] d);
        req_data[i*W +: W] = d;
    endtask

    logic [NR-1:0] g_seq[$];
    int            g_cyc[$];
    int            cyc;

    initial begin
        reset = 1'b0; req = '1; req_data = '0; ro = 1'b0; pol = 1'b0;
        @(posedge clk); #1;

        // 1: reset held with all requests pending
        step(); step();
        chk_val("rst_grant", W'(s_grant), W'(4'b0000));
        chk_val("rst_we",    W'(s_we),    W'(1'b0));
        chk_val("rst_so",    W'(s_so),    W'(1'b0));
        chk_val("rst_err",   W'(s_err),   W'(1'b0));

        // 2: single send, VC bit 0 matches polarity 0
        reset = 1'b1; req = 4'b0100; ro = 1'b1; pol = 1'b0;
        set_slot(2, 64'h0123_4567_89AB_CDEF);
        step();
        `CHK("t2_grant", s_grant, 4'b0100)
        req = '0;
        step();
        `CHK("t2_so_t1", s_so, 1'b0)
        step();
        `CHK("t2_so_t2", s_so, 1'b1)
        `CHK("t2_do",    s_do, 64'h0123_4567_89AB_CDEF)
        step(); step();

        // 3: round-robin from a fresh reset, all requesters held
        reset = 1'b0; step(); reset = 1'b1;
        for (int i = 0; i < NR; i++) set_slot(i, {1'b0, 31'(i), 32'hA5A5_0000});
        req = '1; ro = 1'b1; pol = 1'b0;
        g_seq.delete(); g_cyc.delete();
        for (int c = 0; c < 18; c++) begin
            step();
            if (s_grant != '0) begin g_seq.push_back(s_grant); g_cyc.push_back(c); end
        end
        `CHK("t3_count", g_seq.size() >= 5, 1'b1)
        if (g_seq.size() >= 5) begin
            cyc = 1;
            for (int i = 0; i < 5; i++) begin
                `CHK("t3_order", g_seq[i], 4'(cyc))
                cyc = (cyc == 8) ? 1 : cyc * 2;
                if (i > 0) `CHK("t3_space", g_cyc[i] - g_cyc[i-1], 4)
            end
        end
        req = '0;
        repeat (6) step();

        // 4: polarity backpressure; another requester waits meanwhile
        req = 4'b0001; set_slot(0, 64'h8000_0000_0000_00A5); pol = 1'b0; ro = 1'b1;
        step();
        `CHK("t4_grant", s_grant, 4'b0001)
        req = 4'b0010; set_slot(1, 64'h0000_0000_0000_0011);
        for (int c = 0; c < 5; c++) begin
            step();
            `CHK("t4_hold_so",    s_so,    1'b0)
            `CHK("t4_hold_grant", s_grant, 4'b0000)
        end
        pol = 1'b1;
        step();
        `CHK("t4_pulse", s_so, 1'b1)
        req = '0; pol = 1'b0;
        repeat (4) step();

        // 5: reset while stalled in send, then all requests pending
        req = 4'b0100; set_slot(2, 64'h1111_2222_3333_4444); ro = 1'b0;
        step(); req = '0;
        repeat (3) step();
        reset = 1'b0; step(); reset = 1'b1;
        req = '1; ro = 1'b1; set_slot(0, 64'h0);
        step();
        `CHK("t5_grant", s_grant, 4'b0001)
        `CHK("t5_so",    s_so,    1'b0)
        req = '0;
        repeat (4) step();

        // 6: long stall; error only in the timeout build, sticky after send
        req = 4'b0001; set_slot(0, 64'h0000_0000_0000_0042); ro = 1'b0; pol = 1'b0;
        step(); req = '0;
        repeat (13) step();
`ifdef CARDINAL_NIC_SEND_TIMEOUT_EN
        chk_val("t6_err_set", W'(s_err), W'(1'b1));
`else
        chk_val("t6_err_off", W'(s_err), W'(1'b0));
`endif
        ro = 1'b1;
        step();
        `CHK("t6_send", s_so, 1'b1)
        repeat (3) step();
`ifdef CARDINAL_NIC_SEND_TIMEOUT_EN
        chk_val("t6_sticky", W'(s_err), W'(1'b1));
`else
        chk_val("t6_still0", W'(s_err), W'(1'b0));
`endif
        reset = 1'b0; step(); reset = 1'b1;

        // Random traffic against the model
        for (int c = 0; c < 400; c++) begin
            req = 4'($urandom_range(0, 15));
            ro  = ($urandom % 4) != 0;
            pol = 1'($urandom % 2);
            for (int i = 0; i < NR; i++) set_slot(i, {$urandom, $urandom});
            step();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        if (n_err != 0) $error("FAIL summary: %0d failing checks", n_err);
        $finish;
    end

endmodule
`default_nettype wire
